// File: rtl/core_fetch.sv
// core_fetch: instruction fetch stage with PC ownership, credit-limited requests and an output FIFO.
// Optional build macro CORE_FETCH_ILLEGAL_CHECK_EN flags non-32-bit encodings on out_illegal.
module core_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ir,
    output logic [31:0] out_pc,
    output logic        out_illegal
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [31:0]   req_pc, rsp_pc;
    logic [CW-1:0] outstanding, discard, count;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   ir_mem [DEPTH];
    logic [31:0]   pc_mem [DEPTH];

    logic          req_fire, push, pop;
    logic [CW-1:0] inflight_nxt;
    logic [CW:0]   credit_used;
    logic [31:0]   redirect_base;

    assign redirect_base = redirect_pc & 32'hFFFF_FFFC;
    assign credit_used   = {1'b0, outstanding} + {1'b0, count};
    assign req_fire      = imem_req_valid && imem_req_ready;
    assign push          = (state == RUN) && imem_rsp_valid && !redirect_valid;
    assign pop           = out_valid && out_ready;
    // A request can never fire alongside a redirect, so only a response lowers the in-flight count.
    assign inflight_nxt  = outstanding - (imem_rsp_valid ? ONE : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (redirect_valid && (inflight_nxt != '0)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (redirect_valid) begin
                    state_nxt = (inflight_nxt != '0) ? DRAIN : RUN;
                end else if (imem_rsp_valid && (discard == ONE)) begin
                    state_nxt = RUN;
                end
            end
        endcase
    end

    always_comb begin
        imem_req_valid = rst_n && (state == RUN) && !redirect_valid && (credit_used < DEPTH_W);
        imem_req_addr  = req_pc;
        out_valid      = (count != '0);
        out_ir         = ir_mem[rd_ptr];
        out_pc         = pc_mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pc      <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + (req_fire ? ONE : '0) - (imem_rsp_valid ? ONE : '0);
            if (redirect_valid) begin
                req_pc  <= redirect_base;
                rsp_pc  <= redirect_base;
                discard <= inflight_nxt;
            end else begin
                if (req_fire) req_pc <= req_pc + 32'd4;
                if (push) rsp_pc <= rsp_pc + 32'd4;
                if ((state == DRAIN) && imem_rsp_valid) discard <= discard - ONE;
            end
        end
    end

    // A redirect clears the FIFO after any same-cycle pop has already been delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ir_mem[i] <= '0;
                pc_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                ir_mem[wr_ptr] <= imem_rsp_data;
                pc_mem[wr_ptr] <= rsp_pc;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (push ? ONE : '0) - (pop ? ONE : '0);
        end
    end

`ifdef CORE_FETCH_ILLEGAL_CHECK_EN
    logic ill_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ill_mem[i] <= 1'b0;
            end
        end else if (push) begin
            ill_mem[wr_ptr] <= (imem_rsp_data[1:0] != 2'b11);
        end
    end

    assign out_illegal = out_valid && ill_mem[rd_ptr];
`else
    assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_core_fetch.sv
// tb_core_fetch: directed checks of core_fetch against an in-order instruction memory model.
// Instruction words are a fixed function of address so expected out_ir values follow from out_pc.
module tb_core_fetch;
    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ir;
    logic [31:0] out_pc;
    logic        out_illegal;

`ifdef CORE_FETCH_ILLEGAL_CHECK_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;
    int lat = 1;
    int cyc = 0;
    int req_count = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];

    core_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ir         (out_ir),
        .out_pc         (out_pc),
        .out_illegal    (out_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] dw(input logic [31:0] a);
        if (a == 32'h0000_0300) return 32'h0000_4501;
        if (a == 32'h0000_0304) return 32'h0000_0013;
        return (a | 32'h0000_0003) ^ 32'h5A00_0000;
    endfunction

    // Memory samples the handshake just before each rising edge and answers in order after lat cycles.
    initial begin
        logic        hs;
        logic        rst_seen;
        logic [31:0] a;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #4;
            hs       = imem_req_valid && imem_req_ready;
            a        = imem_req_addr;
            rst_seen = rst_n;
            @(posedge clk);
            cyc++;
            if (!rst_seen) begin
                q_addr.delete();
                q_due.delete();
                req_count = 0;
            end else if (hs) begin
                q_addr.push_back(a);
                q_due.push_back(cyc + lat - 1);
                req_count++;
            end
            #1;
            if (q_due.size() > 0 && q_due[0] == cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = dw(q_addr[0]);
                q_addr.pop_front();
                q_due.pop_front();
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic ordy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = ordy;
    endtask

    task automatic applyReset(input int latency);
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        lat = latency;
        repeat (2) @(negedge clk);
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;

        $display("[TB] reset values and streaming fetch");
        applyReset(1);
        checkOutput("rst_req_valid", imem_req_valid, 1'b0);
        checkOutput("rst_req_addr", imem_req_addr, 32'h0);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_out_ir", out_ir, 32'h0);
        checkOutput("rst_out_pc", out_pc, 32'h0);
        checkOutput("rst_out_illegal", out_illegal, 1'b0);
        rst_n = 1'b1; imem_req_ready = 1'b1; applyStimulus(1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("s_c0_req_valid", imem_req_valid, 1'b1);
        checkOutput("s_c0_req_addr", imem_req_addr, 32'h0);
        cycle();
        checkOutput("s_c1_req_addr", imem_req_addr, 32'h4);
        checkOutput("s_c1_out_valid", out_valid, 1'b0);
        cycle();
        checkOutput("s_c2_req_valid", imem_req_valid, 1'b0);
        checkOutput("s_c2_out_valid", out_valid, 1'b1);
        checkOutput("s_c2_out_pc", out_pc, 32'h0);
        checkOutput("s_c2_out_ir", out_ir, dw(32'h0));
        cycle();
        checkOutput("s_c3_req_valid", imem_req_valid, 1'b1);
        checkOutput("s_c3_req_addr", imem_req_addr, 32'h8);
        checkOutput("s_c3_out_pc", out_pc, 32'h4);
        checkOutput("s_c3_out_ir", out_ir, dw(32'h4));
        cycle();
        checkOutput("s_c4_out_valid", out_valid, 1'b0);
        cycle();
        checkOutput("s_c5_out_valid", out_valid, 1'b1);
        checkOutput("s_c5_out_pc", out_pc, 32'h8);
        checkOutput("s_c5_out_ir", out_ir, dw(32'h8));

        $display("[TB] backpressure from decode");
        applyReset(1);
        rst_n = 1'b1; imem_req_ready = 1'b1; applyStimulus(1'b0, 32'h0, 1'b0);
        cycle(); cycle(); cycle();
        checkOutput("bp_c3_req_valid", imem_req_valid, 1'b0);
        checkOutput("bp_c3_out_pc", out_pc, 32'h0);
        checkOutput("bp_c3_out_ir", out_ir, dw(32'h0));
        cycle();
        checkOutput("bp_c4_req_valid", imem_req_valid, 1'b0);
        checkOutput("bp_req_count", req_count, 2);
        out_ready = 1'b1;
        cycle();
        checkOutput("bp_c5_req_valid", imem_req_valid, 1'b1);
        checkOutput("bp_c5_req_addr", imem_req_addr, 32'h8);
        checkOutput("bp_c5_out_pc", out_pc, 32'h4);

        $display("[TB] redirect with two requests in flight");
        applyReset(3);
        rst_n = 1'b1; imem_req_ready = 1'b1; applyStimulus(1'b0, 32'h0, 1'b1);
        cycle(); cycle();
        applyStimulus(1'b1, 32'h100, 1'b1);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("dr_c3_out_valid", out_valid, 1'b0);
        checkOutput("dr_c3_req_valid", imem_req_valid, 1'b0);
        cycle();
        checkOutput("dr_c4_out_valid", out_valid, 1'b0);
        checkOutput("dr_c4_req_valid", imem_req_valid, 1'b0);
        cycle();
        checkOutput("dr_c5_req_valid", imem_req_valid, 1'b1);
        checkOutput("dr_c5_req_addr", imem_req_addr, 32'h100);
        checkOutput("dr_c5_out_valid", out_valid, 1'b0);
        cycle(); cycle(); cycle();
        checkOutput("dr_c8_out_valid", out_valid, 1'b0);
        cycle();
        checkOutput("dr_c9_out_valid", out_valid, 1'b1);
        checkOutput("dr_c9_out_pc", out_pc, 32'h100);
        checkOutput("dr_c9_out_ir", out_ir, dw(32'h100));

        $display("[TB] redirect with response and delivery in the same cycle");
        applyReset(1);
        rst_n = 1'b1; imem_req_ready = 1'b1; applyStimulus(1'b1, 32'h10, 1'b0);
        #1;
        checkOutput("rs_c0_req_valid", imem_req_valid, 1'b0);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("rs_c1_req_addr", imem_req_addr, 32'h10);
        cycle(); cycle();
        applyStimulus(1'b1, 32'h203, 1'b1);
        #1;
        checkOutput("rs_c3_out_valid", out_valid, 1'b1);
        checkOutput("rs_c3_out_pc", out_pc, 32'h10);
        checkOutput("rs_c3_out_ir", out_ir, dw(32'h10));
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("rs_c4_out_valid", out_valid, 1'b0);
        checkOutput("rs_c4_req_valid", imem_req_valid, 1'b1);
        checkOutput("rs_c4_req_addr", imem_req_addr, 32'h200);
        cycle(); cycle();
        checkOutput("rs_c6_out_pc", out_pc, 32'h200);
        checkOutput("rs_c6_out_ir", out_ir, dw(32'h200));

        $display("[TB] PC wrap-around");
        applyReset(1);
        rst_n = 1'b1; imem_req_ready = 1'b1; applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("wr_c1_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        cycle();
        checkOutput("wr_c2_req_valid", imem_req_valid, 1'b1);
        checkOutput("wr_c2_req_addr", imem_req_addr, 32'h0);
        cycle();
        checkOutput("wr_c3_out_pc", out_pc, 32'hFFFF_FFFC);
        cycle();
        checkOutput("wr_c4_out_pc", out_pc, 32'h0);
        checkOutput("wr_c4_out_ir", out_ir, dw(32'h0));

        $display("[TB] illegal encoding flag");
        applyReset(1);
        rst_n = 1'b1; imem_req_ready = 1'b1; applyStimulus(1'b1, 32'h300, 1'b0);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        cycle(); cycle();
        checkOutput("il_c3_out_pc", out_pc, 32'h300);
        checkOutput("il_c3_out_ir", out_ir, 32'h0000_4501);
        checkOutput("il_c3_out_illegal", out_illegal, ILL_EN);
        cycle();
        out_ready = 1'b1;
        cycle();
        checkOutput("il_c5_out_pc", out_pc, 32'h304);
        checkOutput("il_c5_out_ir", out_ir, 32'h0000_0013);
        checkOutput("il_c5_out_illegal", out_illegal, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
